tcp_tx_ctrl: RTL and testbench

//  Control FSM for the TCP TX protocol-calc datapath (tcp_tx_datap). Accepts one scheduler request at a

---
 rtl/tcp_pkg.sv | 13 +
 rtl/tcp_tx_ctrl_join.sv | 30 +++
 rtl/tcp_tx_ctrl.sv | 171 +++++++++++++++++
 tb/tb_tcp_tx_ctrl.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_pkg.sv
// Shared types for the TCP TX protocol-calc control path.
// State encoding for the tcp_tx_ctrl sequencer.
package tcp_pkg;

  typedef enum logic [2:0] {
    READY   = 3'd0,
    RD_REQ  = 3'd1,
    RD_RESP = 3'd2,
    CALC    = 3'd3,
    OUTPUT  = 3'd4
  } tcp_tx_ctrl_state_e;

endpackage

// File: rtl/tcp_tx_ctrl_join.sv
// N-channel val/rdy issue tracker with sticky per-channel done flags.
// Flags self-clear the cycle all enabled channels have completed.
module tcp_tx_ctrl_join #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         active,
  input  logic [N-1:0] mask,
  input  logic [N-1:0] rdy,
  output logic [N-1:0] val,
  output logic         all_done
);

  logic [N-1:0] done_q;
  logic [N-1:0] hs;

  assign val      = {N{active}} & mask & ~done_q;
  assign hs       = val & rdy;
  assign all_done = active & (&(done_q | hs | ~mask));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= '0;
    end else if (active) begin
      done_q <= all_done ? '0 : (done_q | hs);
    end
  end

endmodule

// File: rtl/tcp_tx_ctrl.sv
// Control FSM for the TCP TX protocol-calc datapath, one flow in flight.
// Optional perf counters enabled by defining TCP_TX_CTRL_PERF_EN.
module tcp_tx_ctrl
  import tcp_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic sched_tx_req_val,
  output logic sched_tx_req_rdy,
  output logic tx_tail_ptr_rd_req_val,
  input  logic tx_tail_ptr_rd_req_rdy,
  input  logic tx_tail_ptr_rd_resp_val,
  output logic tx_tail_ptr_rd_resp_rdy,
  output logic curr_tx_state_rd_req_val,
  input  logic curr_tx_state_rd_req_rdy,
  input  logic curr_tx_state_rd_resp_val,
  output logic curr_tx_state_rd_resp_rdy,
  output logic rx_state_rd_req_val,
  input  logic rx_state_rd_req_rdy,
  input  logic rx_state_rd_resp_val,
  output logic rx_state_rd_resp_rdy,
  output logic tuple_rd_req_val,
  input  logic tuple_rd_req_rdy,
  input  logic tuple_rd_resp_val,
  output logic tuple_rd_resp_rdy,
  output logic next_tx_state_wr_req_val,
  input  logic next_tx_state_wr_req_rdy,
  output logic tx_sched_update_val,
  input  logic tx_sched_update_rdy,
  output logic proto_calc_tx_pkt_val,
  input  logic proto_calc_tx_pkt_rdy,
  output logic ctrl_datap_store_flowid,
  output logic ctrl_datap_store_state,
  output logic ctrl_datap_store_calc,
  output logic ctrl_datap_store_tuple,
  input  logic datap_ctrl_produce_pkt
`ifdef TCP_TX_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_pkts_sent,
  output logic [CNT_W-1:0] perf_reqs_idle
`endif
);

  tcp_tx_ctrl_state_e state;

  logic       st_done, tu_done;
  logic       first_q, need_q, need;
  logic       req_hs;
  logic [3:0] rd_val, rd_rdy;
  logic       rd_all;
  logic       in_resp, st_hs, tu_hs, resp_all;
  logic [2:0] out_val, out_rdy;
  logic       out_all;

  assign sched_tx_req_rdy = rst & (state == READY);
  assign req_hs = sched_tx_req_val & sched_tx_req_rdy;

  assign rd_rdy = {tuple_rd_req_rdy, rx_state_rd_req_rdy,
                   curr_tx_state_rd_req_rdy, tx_tail_ptr_rd_req_rdy};

  tcp_tx_ctrl_join #(.N(4)) u_rd_join (
    .clk      (clk),
    .rst      (rst),
    .active   (state == RD_REQ),
    .mask     (4'hf),
    .rdy      (rd_rdy),
    .val      (rd_val),
    .all_done (rd_all)
  );

  assign tx_tail_ptr_rd_req_val   = rd_val[0];
  assign curr_tx_state_rd_req_val = rd_val[1];
  assign rx_state_rd_req_val      = rd_val[2];
  assign tuple_rd_req_val         = rd_val[3];

  // State words are consumed together so the datap sees a coherent snapshot
  assign in_resp = (state == RD_RESP);
  assign st_hs = in_resp & ~st_done & tx_tail_ptr_rd_resp_val
               & curr_tx_state_rd_resp_val & rx_state_rd_resp_val;
  assign tu_hs = in_resp & ~tu_done & tuple_rd_resp_val;
  assign resp_all = (st_done | st_hs) & (tu_done | tu_hs);

  assign tx_tail_ptr_rd_resp_rdy   = st_hs;
  assign curr_tx_state_rd_resp_rdy = st_hs;
  assign rx_state_rd_resp_rdy      = st_hs;
  assign tuple_rd_resp_rdy         = tu_hs;

  assign ctrl_datap_store_flowid = req_hs;
  assign ctrl_datap_store_state  = st_hs;
  assign ctrl_datap_store_tuple  = tu_hs;
  assign ctrl_datap_store_calc   = (state == CALC);

  // produce_pkt is live on OUTPUT entry, then held for the rest of OUTPUT
  assign need = first_q ? datap_ctrl_produce_pkt : need_q;

  assign out_rdy = {proto_calc_tx_pkt_rdy, tx_sched_update_rdy,
                    next_tx_state_wr_req_rdy};

  tcp_tx_ctrl_join #(.N(3)) u_out_join (
    .clk      (clk),
    .rst      (rst),
    .active   (state == OUTPUT),
    .mask     ({need, 2'b11}),
    .rdy      (out_rdy),
    .val      (out_val),
    .all_done (out_all)
  );

  assign next_tx_state_wr_req_val = out_val[0];
  assign tx_sched_update_val      = out_val[1];
  assign proto_calc_tx_pkt_val    = out_val[2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= READY;
      st_done <= 1'b0;
      tu_done <= 1'b0;
      first_q <= 1'b0;
      need_q  <= 1'b0;
    end else begin
      unique case (state)
        READY: begin
          if (req_hs) state <= RD_REQ;
        end
        RD_REQ: begin
          if (rd_all) state <= RD_RESP;
        end
        RD_RESP: begin
          if (resp_all) begin
            state   <= CALC;
            st_done <= 1'b0;
            tu_done <= 1'b0;
          end else begin
            st_done <= st_done | st_hs;
            tu_done <= tu_done | tu_hs;
          end
        end
        CALC: begin
          state   <= OUTPUT;
          first_q <= 1'b1;
        end
        OUTPUT: begin
          first_q <= 1'b0;
          need_q  <= need;
          if (out_all) state <= READY;
        end
        default: state <= READY;
      endcase
    end
  end

`ifdef TCP_TX_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_pkts_sent <= '0;
      perf_reqs_idle <= '0;
    end else begin
      if (proto_calc_tx_pkt_val & proto_calc_tx_pkt_rdy)
        perf_pkts_sent <= perf_pkts_sent + 1'b1;
      if (out_all & ~need)
        perf_reqs_idle <= perf_reqs_idle + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_tcp_tx_ctrl.sv
// Directed bench for tcp_tx_ctrl with a cycle-stepped memory model.
// Perf counter checks compile in when TCP_TX_CTRL_PERF_EN is defined.
module tb_tcp_tx_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       sched_val = 1'b0;
  logic       produce = 1'b0;
  logic [3:0] req_rdy = 4'hf;
  logic [3:0] resp_val = 4'h0;
  logic       wr_rdy = 1'b1, upd_rdy = 1'b1, pkt_rdy = 1'b1;
  wire  [3:0] req_val, resp_rdy;
  wire        sched_rdy, wr_val, upd_val, pkt_val;
  wire        s_flow, s_state, s_calc, s_tuple;
`ifdef TCP_TX_CTRL_PERF_EN
  wire [31:0] perf_pkts, perf_idle;
`endif

  tcp_tx_ctrl dut (
    .clk                       (clk),
    .rst                       (rst),
    .sched_tx_req_val          (sched_val),
    .sched_tx_req_rdy          (sched_rdy),
    .tx_tail_ptr_rd_req_val    (req_val[0]),
    .tx_tail_ptr_rd_req_rdy    (req_rdy[0]),
    .tx_tail_ptr_rd_resp_val   (resp_val[0]),
    .tx_tail_ptr_rd_resp_rdy   (resp_rdy[0]),
    .curr_tx_state_rd_req_val  (req_val[1]),
    .curr_tx_state_rd_req_rdy  (req_rdy[1]),
    .curr_tx_state_rd_resp_val (resp_val[1]),
    .curr_tx_state_rd_resp_rdy (resp_rdy[1]),
    .rx_state_rd_req_val       (req_val[2]),
    .rx_state_rd_req_rdy       (req_rdy[2]),
    .rx_state_rd_resp_val      (resp_val[2]),
    .rx_state_rd_resp_rdy      (resp_rdy[2]),
    .tuple_rd_req_val          (req_val[3]),
    .tuple_rd_req_rdy          (req_rdy[3]),
    .tuple_rd_resp_val         (resp_val[3]),
    .tuple_rd_resp_rdy         (resp_rdy[3]),
    .next_tx_state_wr_req_val  (wr_val),
    .next_tx_state_wr_req_rdy  (wr_rdy),
    .tx_sched_update_val       (upd_val),
    .tx_sched_update_rdy       (upd_rdy),
    .proto_calc_tx_pkt_val     (pkt_val),
    .proto_calc_tx_pkt_rdy     (pkt_rdy),
    .ctrl_datap_store_flowid   (s_flow),
    .ctrl_datap_store_state    (s_state),
    .ctrl_datap_store_calc     (s_calc),
    .ctrl_datap_store_tuple    (s_tuple),
    .datap_ctrl_produce_pkt    (produce)
`ifdef TCP_TX_CTRL_PERF_EN
    ,
    .perf_pkts_sent            (perf_pkts),
    .perf_reqs_idle            (perf_idle)
`endif
  );

  int errors = 0;
  int checks = 0;

  int dly[4];
  int cnt[4];
  bit pend[4];

  int cyc, n_flow, n_state, n_tuple, n_calc;
  int n_wr, n_upd, n_pkt, n_pktv, bad, t_st, t_tu;
  int n_rs[4];
  int snap_wr[4], snap_upd[4], snap_pkt[4], snap_cyc[4];
  logic [2:0] held = 3'b000;

  task automatic clr_cnt();
    n_flow = 0; n_state = 0; n_tuple = 0; n_calc = 0;
    n_wr = 0; n_upd = 0; n_pkt = 0; n_pktv = 0; bad = 0;
    t_st = 0; t_tu = 0;
    for (int i = 0; i < 4; i++) n_rs[i] = 0;
  endtask

  // Capture this cycle's handshakes, cross the edge, then update the memory model
  task automatic tick();
    logic [3:0] rq, rs;
    logic [2:0] ov, orr;
    rq  = req_val & req_rdy;
    rs  = resp_val & resp_rdy;
    ov  = {pkt_val, upd_val, wr_val};
    orr = {pkt_rdy, upd_rdy, wr_rdy};
    if (s_flow) begin
      if (n_flow < 4) begin
        snap_wr[n_flow]  = n_wr;
        snap_upd[n_flow] = n_upd;
        snap_pkt[n_flow] = n_pkt;
        snap_cyc[n_flow] = cyc;
      end
      n_flow++;
    end
    if (s_state) begin
      n_state++;
      t_st = cyc;
      if (resp_val[2:0] !== 3'b111) bad++;
    end
    if (s_tuple) begin
      n_tuple++;
      t_tu = cyc;
    end
    if (s_calc) n_calc++;
    if (int'(s_flow) + int'(s_calc) + int'(s_state | s_tuple) > 1) bad++;
    if ((held & ~ov) != 3'b000) bad++;
    held = ov & ~orr;
    for (int i = 0; i < 4; i++) if (rs[i]) n_rs[i]++;
    if (wr_val & wr_rdy) n_wr++;
    if (upd_val & upd_rdy) n_upd++;
    if (pkt_val & pkt_rdy) n_pkt++;
    if (pkt_val) n_pktv++;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (rs[i]) resp_val[i] = 1'b0;
      if (rq[i]) begin
        pend[i] = 1'b1;
        cnt[i]  = dly[i];
      end
      if (pend[i]) begin
        if (cnt[i] == 0) begin
          resp_val[i] = 1'b1;
          pend[i] = 1'b0;
        end else begin
          cnt[i]--;
        end
      end
    end
    #1;
  endtask

  task automatic set_dly(input int a, input int b, input int c, input int d);
    dly[0] = a; dly[1] = b; dly[2] = c; dly[3] = d;
  endtask

  task automatic run_req();
    int k;
    k = 0;
    sched_val = 1'b1;
    #1;
    while (!sched_rdy && k < 200) begin
      tick();
      k++;
    end
    tick();
    sched_val = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!sched_rdy && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (sched_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_sched_rdy got=%b exp=0", sched_rdy);
    end
    checks++;
    if ({req_val, resp_rdy, wr_val, upd_val, pkt_val} !== 11'h0) begin
      errors++;
      $display("FAIL reset_vals got=%h exp=0",
               {req_val, resp_rdy, wr_val, upd_val, pkt_val});
    end
    checks++;
    if ({s_flow, s_state, s_calc, s_tuple} !== 4'h0) begin
      errors++;
      $display("FAIL reset_strobes got=%h exp=0",
               {s_flow, s_state, s_calc, s_tuple});
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (sched_rdy !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_rdy got=%b exp=1", sched_rdy);
    end
`ifdef TCP_TX_CTRL_PERF_EN
    checks++;
    if (perf_pkts !== 32'd0 || perf_idle !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_pkts, perf_idle);
    end
`endif
  endtask

  task automatic test_basic();
    int lat, n;
    clr_cnt();
    set_dly(0, 0, 0, 0);
    produce = 1'b1;
    sched_val = 1'b1;
    #1;
    checks++;
    if ({sched_rdy, s_flow} !== 2'b11) begin
      errors++;
      $display("FAIL basic_accept got=%b exp=11", {sched_rdy, s_flow});
    end
    tick();
    sched_val = 1'b0;
    lat = 1;
    while (pkt_val !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL basic_latency got=%0d exp=4", lat);
    end
    checks++;
    if ({wr_val, upd_val} !== 2'b11) begin
      errors++;
      $display("FAIL basic_parallel got=%b exp=11", {wr_val, upd_val});
    end
    tick();
    checks++;
    if (sched_rdy !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready got=%b exp=1", sched_rdy);
    end
    wait_idle(n);
    checks++;
    if (n_pkt != 1 || n_wr != 1 || n_upd != 1 || n_calc != 1) begin
      errors++;
      $display("FAIL basic_counts got=%0d%0d%0d%0d exp=1111",
               n_pkt, n_wr, n_upd, n_calc);
    end
  endtask

  task automatic test_resp_order();
    int n;
    clr_cnt();
    set_dly(3, 3, 5, 0);
    produce = 1'b1;
    run_req();
    wait_idle(n);
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL order_timeout got=%0d exp<200", n);
    end
    checks++;
    if (n_state != 1 || n_tuple != 1) begin
      errors++;
      $display("FAIL order_stores got=%0d/%0d exp=1/1", n_state, n_tuple);
    end
    checks++;
    if (t_st - t_tu != 5) begin
      errors++;
      $display("FAIL order_gap got=%0d exp=5", t_st - t_tu);
    end
    checks++;
    if (n_rs[0] != 1 || n_rs[1] != 1 || n_rs[2] != 1 || n_rs[3] != 1) begin
      errors++;
      $display("FAIL order_resp_hs got=%0d%0d%0d%0d exp=1111",
               n_rs[0], n_rs[1], n_rs[2], n_rs[3]);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL order_protocol got=%0d exp=0", bad);
    end
  endtask

  task automatic test_no_pkt();
    int n;
    clr_cnt();
    set_dly(0, 0, 0, 0);
    produce = 1'b0;
    run_req();
    wait_idle(n);
    checks++;
    if (n_pktv != 0) begin
      errors++;
      $display("FAIL nopkt_val got=%0d exp=0", n_pktv);
    end
    checks++;
    if (n_wr != 1 || n_upd != 1) begin
      errors++;
      $display("FAIL nopkt_wb got=%0d/%0d exp=1/1", n_wr, n_upd);
    end
`ifdef TCP_TX_CTRL_PERF_EN
    checks++;
    if (perf_idle !== 32'd1 || perf_pkts !== 32'd2) begin
      errors++;
      $display("FAIL nopkt_perf got=%0d/%0d exp=1/2", perf_idle, perf_pkts);
    end
`endif
    produce = 1'b1;
  endtask

  task automatic test_pkt_stall();
    int k;
    clr_cnt();
    set_dly(0, 0, 0, 0);
    pkt_rdy = 1'b0;
    run_req();
    k = 0;
    while (pkt_val !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    checks++;
    if (pkt_val !== 1'b1) begin
      errors++;
      $display("FAIL stall_pkt_val got=%b exp=1", pkt_val);
    end
    tick();
    checks++;
    if ({wr_val, upd_val} !== 2'b00 || n_wr != 1 || n_upd != 1) begin
      errors++;
      $display("FAIL stall_early_done got=%b/%0d/%0d exp=00/1/1",
               {wr_val, upd_val}, n_wr, n_upd);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({pkt_val, sched_rdy} !== 2'b10) begin
        errors++;
        $display("FAIL stall_hold got=%b exp=10", {pkt_val, sched_rdy});
      end
      tick();
    end
    pkt_rdy = 1'b1;
    #1;
    tick();
    checks++;
    if (sched_rdy !== 1'b1 || n_pkt != 1 || bad != 0) begin
      errors++;
      $display("FAIL stall_exit got=%b/%0d/%0d exp=1/1/0",
               sched_rdy, n_pkt, bad);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    set_dly(0, 0, 10, 0);
    resp_val = 4'hf;
    #1;
    checks++;
    if (resp_rdy !== 4'h0) begin
      errors++;
      $display("FAIL stray_resp got=%h exp=0", resp_rdy);
    end
    resp_val = 4'h0;
    run_req();
    repeat (3) tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({req_val, resp_rdy, wr_val, upd_val, pkt_val, sched_rdy} !== 12'h0) begin
      errors++;
      $display("FAIL midrst_vals got=%h exp=0",
               {req_val, resp_rdy, wr_val, upd_val, pkt_val, sched_rdy});
    end
    for (int i = 0; i < 4; i++) pend[i] = 1'b0;
    resp_val = 4'h0;
    held = 3'b000;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    clr_cnt();
    set_dly(0, 0, 0, 0);
    run_req();
    wait_idle(n);
    checks++;
    if (n_wr != 1 || n_upd != 1 || n_state != 1 || n_pkt != 1) begin
      errors++;
      $display("FAIL midrst_after got=%0d%0d%0d%0d exp=1111",
               n_wr, n_upd, n_state, n_pkt);
    end
  endtask

  task automatic test_back_to_back();
    int k, n;
    clr_cnt();
    set_dly(0, 0, 0, 0);
    produce = 1'b1;
    sched_val = 1'b1;
    #1;
    k = 0;
    while (n_flow < 2 && k < 60) begin
      tick();
      k++;
    end
    sched_val = 1'b0;
    checks++;
    if (n_flow != 2) begin
      errors++;
      $display("FAIL b2b_accepts got=%0d exp=2", n_flow);
    end
    checks++;
    if (snap_cyc[1] - snap_cyc[0] != 5) begin
      errors++;
      $display("FAIL b2b_spacing got=%0d exp=5", snap_cyc[1] - snap_cyc[0]);
    end
    checks++;
    if (snap_wr[1] - snap_wr[0] != 1 || snap_upd[1] - snap_upd[0] != 1
        || snap_pkt[1] - snap_pkt[0] != 1) begin
      errors++;
      $display("FAIL b2b_first_done got=%0d/%0d/%0d exp=1/1/1",
               snap_wr[1] - snap_wr[0], snap_upd[1] - snap_upd[0],
               snap_pkt[1] - snap_pkt[0]);
    end
    wait_idle(n);
    checks++;
    if (n_pkt != 2 || n_wr != 2 || bad != 0) begin
      errors++;
      $display("FAIL b2b_total got=%0d/%0d/%0d exp=2/2/0", n_pkt, n_wr, bad);
    end
  endtask

  initial begin
    cyc = 0;
    set_dly(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      pend[i] = 1'b0;
      cnt[i] = 0;
    end
    clr_cnt();
    test_reset();
    test_basic();
    test_resp_order();
    test_no_pkt();
    test_pkt_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
